// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path (and the future receive side).
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int MIN_NBITS = 5;

  // Out-of-range frame lengths are pulled back into [MIN_NBITS, max_n].
  function automatic logic [3:0] clamp_nbits(input logic [3:0] n, input logic [3:0] max_n);
    if (n < 4'(MIN_NBITS)) return 4'(MIN_NBITS);
    if (n > max_n) return max_n;
    return n;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered level/full/empty and fall-through read data.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_nxt;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is legal only when a pop frees a slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    if (do_push && !do_pop)
      level_nxt = level + 1'b1;
    else if (do_pop && !do_push)
      level_nxt = level - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      full  <= (level_nxt == FULL_LVL);
      empty <= (level_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: AXIS sink -> FIFO -> serialiser with runtime frame format.
// Optional line break generation (brk_i) is enabled by defining UART_TX_BREAK_EN.
//
// state  | meaning
// IDLE   | line high (or held low during break), waiting for a FIFO word
// START  | start bit, line low for one bit time
// DATA   | nbits data bits, LSB first
// PARITY | parity bit, only when parity is enabled
// STOP   | one or two stop bits, line high
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 17
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
`ifdef UART_TX_BREAK_EN
  input  logic                        brk_i,
`endif
  input  logic [DATA_WIDTH-1:0]       slv_axis_tdata_i,
  input  logic                        slv_axis_tvalid_i,
  output logic                        slv_axis_tready_o,
  input  logic [DIV_WIDTH-1:0]        cfg_div_i,
  input  logic [3:0]                  cfg_nbits_i,
  input  logic [1:0]                  cfg_parity_i,
  input  logic                        cfg_stop2_i,
  output logic                        tx_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  brk;

  tx_state_e             state;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [3:0]            bit_cnt_q;
  logic [DIV_WIDTH-1:0]  timer_q;
  logic [DIV_WIDTH-1:0]  div_m1_q;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  stop2_q;
  logic                  stop_cnt_q;

  logic [3:0]            nbits_ld;
  logic [DIV_WIDTH-1:0]  div_m1_ld;
  logic                  par_en_ld;
  logic                  par_bit_ld;
  logic                  bit_done;
  logic                  frame_end;

`ifdef UART_TX_BREAK_EN
  assign brk = brk_i;
`else
  assign brk = 1'b0;
`endif

  assign slv_axis_tready_o = !fifo_full;
  assign fifo_push = slv_axis_tvalid_i && !fifo_full;
  assign bit_done  = (timer_q == '0);
  assign frame_end = (state == STOP) && bit_done && !stop_cnt_q;
  // Popping at the last stop cycle chains the next frame with no idle gap.
  assign fifo_pop  = !fifo_empty && (((state == IDLE) && !brk) || frame_end);

  uart_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (slv_axis_tdata_i),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level_o)
  );

  // Frame parameters captured at pop time; mid-frame config changes wait for the next frame.
  always_comb begin
    nbits_ld   = clamp_nbits(cfg_nbits_i, 4'(DATA_WIDTH));
    div_m1_ld  = (cfg_div_i == '0) ? '0 : cfg_div_i - 1'b1;
    par_en_ld  = (cfg_parity_i == PAR_EVEN) || (cfg_parity_i == PAR_ODD);
    par_bit_ld = (cfg_parity_i == PAR_ODD);
    for (int i = 0; i < DATA_WIDTH; i++)
      if (i < int'(nbits_ld)) par_bit_ld ^= fifo_rdata[i];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      tx_o       <= 1'b1;
      busy_o     <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      timer_q    <= '0;
      div_m1_q   <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
    end else begin
      if (!bit_done) timer_q <= timer_q - 1'b1;
      if (fifo_pop) begin
        state     <= START;
        tx_o      <= 1'b0;
        busy_o    <= 1'b1;
        shift_q   <= fifo_rdata;
        bit_cnt_q <= nbits_ld - 4'd1;
        timer_q   <= div_m1_ld;
        div_m1_q  <= div_m1_ld;
        par_en_q  <= par_en_ld;
        par_bit_q <= par_bit_ld;
        stop2_q   <= cfg_stop2_i;
      end else begin
        case (state)
          IDLE: begin
            tx_o   <= !brk;
            busy_o <= brk;
          end
          START: if (bit_done) begin
            state   <= DATA;
            tx_o    <= shift_q[0];
            shift_q <= shift_q >> 1;
            timer_q <= div_m1_q;
          end
          DATA: if (bit_done) begin
            timer_q <= div_m1_q;
            if (bit_cnt_q != 4'd0) begin
              tx_o      <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q - 4'd1;
            end else if (par_en_q) begin
              state <= PARITY;
              tx_o  <= par_bit_q;
            end else begin
              state      <= STOP;
              tx_o       <= 1'b1;
              stop_cnt_q <= stop2_q;
            end
          end
          PARITY: if (bit_done) begin
            state      <= STOP;
            tx_o       <= 1'b1;
            stop_cnt_q <= stop2_q;
            timer_q    <= div_m1_q;
          end
          STOP: if (bit_done) begin
            if (stop_cnt_q) begin
              stop_cnt_q <= 1'b0;
              timer_q    <= div_m1_q;
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
